if_stage_fetch: RTL

- Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS processor. It sits directly upstream of decode.
- Owns the program counter and drives the instruction-ROM address. The ROM is combinational-read.
- Captures the fetched instruction and PC+4 into the IF/ID register.
- Honours load-use stalls from the hazard unit and branch/jump redirects from EX, which flush the wrong-path instruction.

---
 rtl/if_stage_fetch_if.sv | 28 ++
 rtl/if_stage_fetch.sv | 88 ++++++++
 2 files changed

// File: rtl/if_stage_fetch_if.sv
// Fetch-stage bus: run/stall/redirect control from the pipeline, the
// instruction-ROM address/data pair, and the IF/ID register outputs.
interface if_stage_fetch_if #(
  parameter int CNT_W = 16
);
  logic             pc_enable;
  logic             stall;
  logic             redirect;
  logic [31:0]      redirect_target;
  logic [31:0]      rom_addrs;
  logic [31:0]      rom_data;
  logic [31:0]      if_id_instruction;
  logic [31:0]      if_id_pc_plus4;
  logic             if_id_valid;
  logic [CNT_W-1:0] flush_count;

  // Pipeline control, ROM and decode side.
  modport master (
    output pc_enable, stall, redirect, redirect_target, rom_data,
    input  rom_addrs, if_id_instruction, if_id_pc_plus4, if_id_valid, flush_count
  );

  // The fetch stage itself.
  modport slave (
    input  pc_enable, stall, redirect, redirect_target, rom_data,
    output rom_addrs, if_id_instruction, if_id_pc_plus4, if_id_valid, flush_count
  );
endinterface

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: program counter, combinational ROM addressing,
// IF/ID pipeline register and a saturating count of taken redirects.
// Priority per edge: reset > !pc_enable (hold) > redirect > stall > fetch.
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input logic            p_clk,
  input logic            p_rst_s,
  if_stage_fetch_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]      pc_q,    pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc4_q,   pc4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [31:0]      pc_plus4;
  logic [31:0]      target_aligned;

  // 32-bit modulo increment: 32'hFFFF_FFFC wraps to zero silently.
  assign pc_plus4       = pc_q + 32'd4;
  // Word-align the redirect target by clearing the two byte-offset bits.
  assign target_aligned = bus.redirect_target & ~32'h0000_0003;

  // Next-state selection in priority order: disable, redirect, stall, fetch.
  always_comb begin
    // NOTE: every output gets a hold default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (bus.pc_enable) begin
      if (bus.redirect) begin
        // Wrong-path fetch becomes a bubble; redirect overrides any stall.
        pc_d    = target_aligned;
        instr_d = NOP_INSTR;
        pc4_d   = 32'h0000_0000;
        valid_d = 1'b0;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_ONE;
      end else if (!bus.stall) begin
        pc_d    = pc_plus4;
        instr_d = bus.rom_data;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    end
  end

  // Program counter register.
  always_ff @(posedge p_clk or posedge p_rst_s) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values, independent of block ordering.
    if (p_rst_s) pc_q <= RESET_PC;
    else         pc_q <= pc_d;
  end

  // IF/ID pipeline register.
  always_ff @(posedge p_clk or posedge p_rst_s) begin
    if (p_rst_s) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  // Saturating redirect counter.
  always_ff @(posedge p_clk or posedge p_rst_s) begin
    if (p_rst_s) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign bus.rom_addrs         = pc_q;
  assign bus.if_id_instruction = instr_q;
  assign bus.if_id_pc_plus4    = pc4_q;
  assign bus.if_id_valid       = valid_q;
  assign bus.flush_count       = cnt_q;

endmodule
